// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   state_t  : controller states (IDLE / RUN / DONE)
//   MODE_ADD : mode encoding for a + b
//   MODE_SUB : mode encoding for a - b (computed as a + ~b + 1)
//   cnt_width: width of the bit counter for a given operand width
// ---------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bit counter only has to reach WIDTH-1, so ceil(log2(WIDTH)) bits suffice.
  // Clamp to one bit so a degenerate width still yields a legal vector.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : addsub_pkg

// File: rtl/addsub_bit.sv
// ---------------------------------------------------------------------------
// addsub_bit
// Combinational one-bit add/subtract cell. Operand b is inverted when sub
// is set; together with a carry-in of 1 on the first bit this turns the
// adder into a two's-complement subtractor.
// Ports:
//   a    in  1 : operand A bit
//   b    in  1 : operand B bit (before conditional inversion)
//   cin  in  1 : carry in
//   sub  in  1 : 1 = subtract (invert b)
//   s    out 1 : sum / difference bit
//   cout out 1 : carry out (for subtract: 1 = no borrow)
// ---------------------------------------------------------------------------
module addsub_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  logic w_b;
  logic w_p;

  assign w_b  = b ^ sub;
  assign w_p  = a ^ w_b;          // propagate
  assign s    = w_p ^ cin;
  assign cout = (a & w_b) | (cin & w_p);

endmodule : addsub_bit

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Bit-serial adder/subtractor. Operands are captured on an accepted start
// and processed LSB-first, one bit per clock, through a single addsub_bit
// cell with a registered carry. Results are published in one step when the
// last bit completes, so they never show a partially built value.
// Ports:
//   clk      in  1     : rising-edge clock
//   rst      in  1     : asynchronous active-high reset
//   start    in  1     : request, sampled only in IDLE or DONE
//   mode     in  1     : 0 = a+b, 1 = a-b (captured with start)
//   a        in  WIDTH : operand A (captured with start)
//   b        in  WIDTH : operand B (captured with start)
//   busy     out 1     : high while bits are being processed
//   done     out 1     : one-cycle pulse, results valid from this cycle on
//   result   out WIDTH : sum / difference, held until the next operation
//   cout     out 1     : final carry (subtract: 1 = no borrow)
//   overflow out 1     : two's-complement signed overflow
// ---------------------------------------------------------------------------
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum_sr;   // partial sum, fills from the MSB end
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_mode;
  logic             r_carry;
  logic             r_cout;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;

  logic             w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum_sr_next;

  addsub_bit u_bit (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sub  (r_mode),
    .s    (w_sum),
    .cout (w_carry)
  );

  // New sum bit enters at the MSB while the register shifts right; after
  // WIDTH shifts the LSB computed first has reached bit 0.
  assign w_sum_sr_next = WIDTH'({w_sum, r_sum_sr} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sum_sr   <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_mode     <= MODE_ADD;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_mode  <= mode;
            // Subtraction needs the +1 of the two's complement of b, which
            // is injected as the initial carry.
            r_carry <= mode;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end

        RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_sum_sr <= w_sum_sr_next;
          r_carry  <= w_carry;
          if (r_cnt == LAST_BIT) begin
            // r_carry is the carry into the MSB, w_carry the carry out;
            // they differ exactly when the signed result overflows.
            r_result   <= w_sum_sr_next;
            r_cout     <= w_carry;
            r_overflow <= r_carry ^ w_carry;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule : serial_addsub

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
// Directed checks of serial_addsub at WIDTH=8 plus an exhaustive sweep of a
// WIDTH=4 instance against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_serial_addsub;
  import addsub_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       overflow;

  logic       s4_start;
  logic       s4_mode;
  logic [3:0] s4_a;
  logic [3:0] s4_b;
  logic       s4_busy;
  logic       s4_done;
  logic [3:0] s4_result;
  logic       s4_cout;
  logic       s4_overflow;

  int checks;
  int errors;

  serial_addsub #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .start    (s4_start),
    .mode     (s4_mode),
    .a        (s4_a),
    .b        (s4_b),
    .busy     (s4_busy),
    .done     (s4_done),
    .result   (s4_result),
    .cout     (s4_cout),
    .overflow (s4_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle, then scramble the inputs so that any
  // later sampling of them would corrupt the result. Ends on the negedge
  // after the accepting edge.
  task automatic launch(input logic m, input logic [7:0] xa, input logic [7:0] xb);
    @(negedge clk);
    mode  = m;
    a     = xa;
    b     = xb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    a     = ~xa;
    b     = xb ^ 8'h5A;
  endtask

  // Called on the first negedge after the accepting edge. lat counts edges
  // after the accepting edge until done is seen; busy_cnt counts cycles with
  // busy high. Optionally pulses start with fresh operands mid-RUN.
  task automatic wait_done(input bit inject, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (inject && lat == 3) begin
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h22;
        mode  = ~mode;
      end
      if (inject && lat == 4) start = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input int lat, input int busy_cnt,
                          input logic [7:0] er, input logic ec, input logic eo);
    $display("op %s: result=%02h cout=%0b overflow=%0b latency=%0d busy_cycles=%0d",
             tag, result, cout, overflow, lat, busy_cnt);
    chk({tag, "_done"},     done, 1'b1);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_latency"},  lat, 8);
    chk({tag, "_busy_cnt"}, busy_cnt, 8);
    chk({tag, "_result"},   result, er);
    chk({tag, "_cout"},     cout, ec);
    chk({tag, "_ovf"},      overflow, eo);
  endtask

  initial begin
    int lat;
    int bc;
    int exp_sum;
    logic [3:0] er4;
    logic       eo4;
    int lat4;

    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    mode     = MODE_ADD;
    a        = '0;
    b        = '0;
    s4_start = 1'b0;
    s4_mode  = MODE_ADD;
    s4_a     = '0;
    s4_b     = '0;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",   busy, 1'b0);
    chk("rst_done",   done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_cout",   cout, 1'b0);
    chk("rst_ovf",    overflow, 1'b0);
    rst = 1'b0;

    // 0x0F + 0x01 = 0x10
    launch(MODE_ADD, 8'h0F, 8'h01);
    wait_done(1'b0, lat, bc);
    check_op("add_0f_01", lat, bc, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_pulse_single", done, 1'b0);
    chk("result_held", result, 8'h10);

    // 0xFF + 0x01 wraps to 0x00 with carry out, no signed overflow
    launch(MODE_ADD, 8'hFF, 8'h01);
    wait_done(1'b0, lat, bc);
    check_op("add_ff_01", lat, bc, 8'h00, 1'b1, 1'b0);

    // 0x7F + 0x01: +127 + 1 overflows to -128
    launch(MODE_ADD, 8'h7F, 8'h01);
    wait_done(1'b0, lat, bc);
    check_op("add_7f_01", lat, bc, 8'h80, 1'b0, 1'b1);

    // 5 - 7 = -2, borrow so cout = 0
    launch(MODE_SUB, 8'h05, 8'h07);
    wait_done(1'b0, lat, bc);
    check_op("sub_05_07", lat, bc, 8'hFE, 1'b0, 1'b0);

    // -128 - 1 overflows to +127, no borrow
    launch(MODE_SUB, 8'h80, 8'h01);
    wait_done(1'b0, lat, bc);
    check_op("sub_80_01", lat, bc, 8'h7F, 1'b1, 1'b1);

    // start mid-RUN with other operands is ignored: 0x21 + 0x13 = 0x34
    launch(MODE_ADD, 8'h21, 8'h13);
    wait_done(1'b1, lat, bc);
    check_op("ignore_start", lat, bc, 8'h34, 1'b0, 1'b0);

    // Back-to-back: 0x40 + 0x40 = 0x80 (overflow), then start held in the
    // DONE cycle: 0x10 - 0x10 = 0x00 with no borrow
    launch(MODE_ADD, 8'h40, 8'h40);
    wait_done(1'b0, lat, bc);
    check_op("b2b_first", lat, bc, 8'h80, 1'b0, 1'b1);
    mode  = MODE_SUB;
    a     = 8'h10;
    b     = 8'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hAA;
    chk("b2b_busy_next", busy, 1'b1);
    wait_done(1'b0, lat, bc);
    check_op("b2b_second", lat, bc, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of RUN
    launch(MODE_ADD, 8'h12, 8'h34);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-RUN: busy=%0b done=%0b result=%02h cout=%0b overflow=%0b",
             busy, done, result, cout, overflow);
    chk("arst_busy",   busy, 1'b0);
    chk("arst_done",   done, 1'b0);
    chk("arst_result", result, 8'h00);
    chk("arst_cout",   cout, 1'b0);
    chk("arst_ovf",    overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    launch(MODE_ADD, 8'h03, 8'h04);
    wait_done(1'b0, lat, bc);
    check_op("post_rst_add", lat, bc, 8'h07, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep against an arithmetic reference
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          @(negedge clk);
          s4_mode  = m[0];
          s4_a     = 4'(x);
          s4_b     = 4'(y);
          s4_start = 1'b1;
          @(negedge clk);
          s4_start = 1'b0;
          lat4 = 0;
          while (s4_done !== 1'b1 && lat4 < 20) begin
            @(negedge clk);
            lat4++;
          end
          if (m == 0) exp_sum = x + y;
          else        exp_sum = x + (15 - y) + 1;
          er4 = 4'(exp_sum);
          // Signed overflow: operands of equal sign (after negating b for
          // subtract) giving a result of the other sign.
          if (m == 0) eo4 = (s4_a[3] == s4_b[3]) && (er4[3] != s4_a[3]);
          else        eo4 = (s4_a[3] != s4_b[3]) && (er4[3] != s4_a[3]);
          $display("w4 op mode=%0d a=%0h b=%0h: result=%0h cout=%0b overflow=%0b",
                   m, x, y, s4_result, s4_cout, s4_overflow);
          chk("w4_done",   s4_done, 1'b1);
          chk("w4_result", s4_result, er4);
          chk("w4_cout",   s4_cout, (exp_sum >= 16) ? 1'b1 : 1'b0);
          chk("w4_ovf",    s4_overflow, eo4);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_addsub
